// File: rtl/dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_arbiter
// Description : Round-robin arbiter sharing a single-port data memory between
//               a CPU port (m0) and a debug/DMA port (m1), with bounded lock.
// Revision    : 1.0  initial release
// ============================================================================
module dm_access_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wd,
   input  logic              m0_lock,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rd,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wd,
   input  logic              m1_lock,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rd,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wd,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rd,
   output logic              lock_timeout
);
   localparam int              CNT_W      = $clog2(LOCK_MAX);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(LOCK_MAX - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              lock_timeout_q, lock_timeout_d;
   logic              m0_rvalid_q, m0_rvalid_d;
   logic              m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] m0_rd_q, m0_rd_d;
   logic [DATA_W-1:0] m1_rd_q, m1_rd_d;
   logic              w_gnt0, w_gnt1;
   logic              w_rel;

   // Grants are gated by reset so nothing reaches the memory while it is held.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               w_gnt0 = m0_req & (~m1_req | ~rr_ptr_q);
               w_gnt1 = m1_req & (~m0_req |  rr_ptr_q);
            end
            LOCK0:   w_gnt0 = m0_req;
            LOCK1:   w_gnt1 = m1_req;
            default: ;
         endcase
      end
   end

   always_comb begin
      dm_addr = '0;
      dm_wd   = '0;
      dm_we   = 1'b0;
      if (w_gnt0) begin
         dm_addr = m0_addr;
         dm_wd   = m0_wd;
         dm_we   = m0_we;
      end else if (w_gnt1) begin
         dm_addr = m1_addr;
         dm_wd   = m1_wd;
         dm_we   = m1_we;
      end
   end

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      lock_cnt_d     = lock_cnt_q;
      lock_timeout_d = 1'b0;
      m0_rvalid_d    = w_gnt0 & ~m0_we;
      m1_rvalid_d    = w_gnt1 & ~m1_we;
      m0_rd_d        = m0_rvalid_d ? dm_rd : m0_rd_q;
      m1_rd_d        = m1_rvalid_d ? dm_rd : m1_rd_q;
      w_rel          = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_gnt0) begin
               if (m0_lock) begin
                  state_d    = LOCK0;
                  lock_cnt_d = '0;
               end else begin
                  rr_ptr_d = 1'b1;
               end
            end else if (w_gnt1) begin
               if (m1_lock) begin
                  state_d    = LOCK1;
                  lock_cnt_d = '0;
               end else begin
                  rr_ptr_d = 1'b0;
               end
            end
         end
         LOCK0, LOCK1: begin
            w_rel = (state_q == LOCK0) ? (w_gnt0 & ~m0_lock) : (w_gnt1 & ~m1_lock);
            // A release coinciding with expiry counts as a clean release.
            if (w_rel || (lock_cnt_q == C_CNT_LAST)) begin
               state_d        = IDLE;
               rr_ptr_d       = (state_q == LOCK0);
               lock_timeout_d = ~w_rel;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         rr_ptr_q       <= 1'b0;
         lock_cnt_q     <= '0;
         lock_timeout_q <= 1'b0;
         m0_rvalid_q    <= 1'b0;
         m1_rvalid_q    <= 1'b0;
         m0_rd_q        <= '0;
         m1_rd_q        <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         lock_cnt_q     <= lock_cnt_d;
         lock_timeout_q <= lock_timeout_d;
         m0_rvalid_q    <= m0_rvalid_d;
         m1_rvalid_q    <= m1_rvalid_d;
         m0_rd_q        <= m0_rd_d;
         m1_rd_q        <= m1_rd_d;
      end
   end

   assign m0_gnt       = w_gnt0;
   assign m1_gnt       = w_gnt1;
   assign m0_rvalid    = m0_rvalid_q;
   assign m1_rvalid    = m1_rvalid_q;
   assign m0_rd        = m0_rd_q;
   assign m1_rd        = m1_rd_q;
   assign lock_timeout = lock_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_arbiter
// Description : Scoreboard bench for dm_access_arbiter with a behavioural memory.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dm_access_arbiter;
   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [4:0]  m0_addr, m1_addr;
   logic [31:0] m0_wd, m1_wd;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rd, m1_rd;
   logic [4:0]  dm_addr;
   logic [31:0] dm_wd, dm_rd;
   logic        dm_we, lock_timeout;

   logic [31:0] mem     [32];
   logic [31:0] ref_mem [32];
   logic [31:0] sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   dm_access_arbiter #(.ADDR_W(5), .DATA_W(32), .LOCK_MAX(8)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_lock(m0_lock),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_lock(m1_lock),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
      .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd),
      .lock_timeout(lock_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port data memory: synchronous write, combinational read.
   assign dm_rd = mem[dm_addr];
   always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wd;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_resp(input string tag, input logic rv, input logic [31:0] rd, input logic exp_rv);
      logic [31:0] e;
      check_val({tag, "_rvalid"}, rv, exp_rv);
      if (exp_rv) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sb: scoreboard empty, got %0h", tag, rd);
         end else begin
            e = sb_q.pop_front();
            check_val({tag, "_rd"}, rd, e);
         end
      end
   endtask

   task automatic step(input logic r0, input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic l0, input logic r1, input logic w1, input logic [4:0] a1,
                       input logic [31:0] d1, input logic l1,
                       input logic eg0, input logic eg1, input logic eto);
      logic       p0, p1, ewe;
      logic [4:0] eaddr;
      @(negedge clk);
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wd = d0; m0_lock = l0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wd = d1; m1_lock = l1;
      #1;
      check_val("m0_gnt", m0_gnt, eg0);
      check_val("m1_gnt", m1_gnt, eg1);
      ewe   = eg0 ? w0 : (eg1 ? w1 : 1'b0);
      eaddr = eg0 ? a0 : (eg1 ? a1 : 5'd0);
      check_val("dm_we", dm_we, ewe);
      check_val("dm_addr", dm_addr, eaddr);
      if (ewe) check_val("dm_wd", dm_wd, eg0 ? d0 : d1);
      p0 = eg0 & ~w0;
      p1 = eg1 & ~w1;
      if (p0) sb_q.push_back(ref_mem[a0]);
      if (p1) sb_q.push_back(ref_mem[a1]);
      if (eg0 && w0) ref_mem[a0] = d0;
      if (eg1 && w1) ref_mem[a1] = d1;
      @(posedge clk);
      #1;
      check_resp("m0", m0_rvalid, m0_rd, p0);
      check_resp("m1", m1_rvalid, m1_rd, p1);
      check_val("lock_timeout", lock_timeout, eto);
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0; m0_lock = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0; m1_lock = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]     = 32'hA500_0000 | i;
         ref_mem[i] = 32'hA500_0000 | i;
      end
      reset = 1'b1;
      idle_inputs();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd2; m0_wd = 32'h1234_5678;
      #1;
      check_val("rst_m0_gnt", m0_gnt, 0);
      check_val("rst_dm_we", dm_we, 0);
      check_val("rst_m0_rvalid", m0_rvalid, 0);
      check_val("rst_m1_rvalid", m1_rvalid, 0);
      check_val("rst_m0_rd", m0_rd, 0);
      check_val("rst_m1_rd", m1_rd, 0);
      check_val("rst_lock_timeout", lock_timeout, 0);
      @(negedge clk);
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;

      // Round-robin tie: m0, m1, m0, m1
      for (int i = 0; i < 4; i++)
         step(1, 0, 5'd1, 0, 0, 1, 0, 5'd2, 0, 0, (i % 2) == 0, (i % 2) == 1, 0);

      // Write then read back by m0
      step(1, 1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // m1 locks (rr now favours m1), m0 blocked until release
      step(1, 0, 5'd4, 0, 0, 1, 0, 5'd7, 0, 1, 0, 1, 0);
      step(1, 0, 5'd4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 5'd4, 0, 0, 1, 1, 5'd7, 32'hCAFE_0007, 0, 0, 1, 0);
      step(1, 0, 5'd7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // m0 locks then idles until forced release after 8 cycles
      step(1, 0, 5'd5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 1; i <= 8; i++)
         step(0, 0, 0, 0, 1, 1, 0, 5'd6, 0, 0, 0, 0, i == 8);
      step(0, 0, 0, 0, 0, 1, 0, 5'd6, 0, 0, 0, 1, 0);

      // m1 releases in the last allowed cycle: no timeout pulse
      step(0, 0, 0, 0, 0, 1, 0, 5'd8, 0, 1, 0, 1, 0);
      for (int i = 1; i <= 7; i++)
         step(1, 0, 5'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 5'd1, 0, 0, 1, 1, 5'd8, 32'h0BAD_F00D, 0, 0, 1, 0);
      step(1, 0, 5'd8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // Reset mid-lock with a read response in flight
      step(0, 0, 0, 0, 0, 1, 0, 5'd10, 0, 1, 0, 1, 0);
      @(negedge clk);
      m0_req = 1; m0_we = 1; m0_addr = 5'd9; m0_wd = 32'h5555_AAAA; m0_lock = 0;
      m1_req = 1; m1_we = 0; m1_addr = 5'd11; m1_lock = 1;
      #1;
      check_val("lk_m0_gnt", m0_gnt, 0);
      check_val("lk_m1_gnt", m1_gnt, 1);
      @(posedge clk);
      #1;
      check_val("lk_m1_rvalid", m1_rvalid, 1);
      #1;
      reset = 1'b1;
      #1;
      check_val("mid_rst_m1_rvalid", m1_rvalid, 0);
      check_val("mid_rst_m1_rd", m1_rd, 0);
      check_val("mid_rst_m0_gnt", m0_gnt, 0);
      check_val("mid_rst_m1_gnt", m1_gnt, 0);
      check_val("mid_rst_dm_we", dm_we, 0);
      m1_req = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_val("rst_wr_dm_we", dm_we, 0);
         check_val("rst_wr_m0_gnt", m0_gnt, 0);
      end
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;

      // Tie after reset goes to m0; addr 9 must still hold its original value
      step(1, 0, 5'd9, 0, 0, 1, 0, 5'd11, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 5'd11, 0, 0, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
